// File: rtl/id_instr_queue.sv
// id_instr_queue: fetch-to-decode instruction FIFO with delay-slot tagging and branch/exception flush.
module id_instr_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int EXC_W = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [31:0]                  in_instr_i,
    input  logic [PC_W-1:0]              in_pc_i,
    input  logic [EXC_W-1:0]             in_exc_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [31:0]                  out_instr_o,
    output logic [PC_W-1:0]              out_pc_o,
    output logic [EXC_W-1:0]             out_exc_o,
    output logic                         out_bd_o,
    input  logic                         redirect_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH):0]       count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic {NORMAL, WAIT_DS} state_e;
    logic [31:0]      instr_q [DEPTH];
    logic [PC_W-1:0]  pc_q    [DEPTH];
    logic [EXC_W-1:0] exc_q   [DEPTH];
    logic             bd_q    [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    count_q, count_d;
    state_e           state_q, state_d;
    logic             last_jmp_q, last_jmp_d;
    logic             push, pop, wr_en, wr_bd, is_jmp;
    logic [5:0]       op, func;

    assign op          = in_instr_i[31:26];
    assign func        = in_instr_i[5:0];
    assign is_jmp      = (op inside {6'b000100, 6'b000101, 6'b000110, 6'b000111,
                                     6'b000001, 6'b000010, 6'b000011})
                       || (op == 6'b000000 && (func == 6'b001000 || func == 6'b001001));
    assign in_ready_o  = count_q != CW'(DEPTH);
    assign out_valid_o = count_q != '0;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign count_o     = count_q;
    assign out_instr_o = out_valid_o ? instr_q[rd_q] : '0;
    assign out_pc_o    = out_valid_o ? pc_q[rd_q]    : '0;
    assign out_exc_o   = out_valid_o ? exc_q[rd_q]   : '0;
    assign out_bd_o    = out_valid_o && bd_q[rd_q];

    always_comb begin
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        state_d    = state_q;
        last_jmp_d = last_jmp_q;
        wr_en      = 1'b0;
        wr_bd      = (state_q == WAIT_DS) || last_jmp_q;
        if (flush_i) begin
            wr_d       = rd_q;
            count_d    = '0;
            state_d    = NORMAL;
            last_jmp_d = 1'b0;
        end else if (redirect_i && pop) begin
            // Only the delay slot survives a taken branch; the target restarts untagged.
            last_jmp_d = 1'b0;
            rd_d       = rd_q + AW'(1);
            if (count_q > CW'(1)) begin
                wr_d    = rd_q + AW'(2);
                count_d = CW'(1);
            end else if (push) begin
                wr_en   = 1'b1;
                wr_bd   = 1'b1;
                wr_d    = wr_q + AW'(1);
                count_d = CW'(1);
            end else begin
                count_d = '0;
                state_d = WAIT_DS;
            end
        end else begin
            wr_en      = push;
            wr_d       = wr_q + AW'(push);
            rd_d       = rd_q + AW'(pop);
            count_d    = count_q + CW'(push) - CW'(pop);
            last_jmp_d = push ? is_jmp : last_jmp_q;
            state_d    = push ? NORMAL : state_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            state_q    <= NORMAL;
            last_jmp_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                exc_q[i]   <= '0;
                bd_q[i]    <= 1'b0;
            end
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            last_jmp_q <= last_jmp_d;
            if (wr_en) begin
                instr_q[wr_q] <= in_instr_i;
                pc_q[wr_q]    <= in_pc_i;
                exc_q[wr_q]   <= in_exc_i;
                bd_q[wr_q]    <= wr_bd;
            end
        end
    end
endmodule

// File: doc/id_instr_queue.md
Name: id_instr_queue

Overview:
- Parametrised instruction buffer between the fetch stage and the decode stage of the MIPS pipeline.
- Replaces the single IF/ID register. Decouples fetch from decode stalls.
- Pre-decodes branch/jump instructions at enqueue so the delay-slot flag (if_bd) travels with each instruction.
- Supports a full flush on exception/eret, and a branch-redirect flush that keeps only the delay slot.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PC_W, 32, width of the stored PC.
- EXC_W, 5, width of the carried ExcCode field (matches ExcCode[6:2]).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- in_valid, input, 1, fetch presents an instruction.
- in_ready, output, 1, queue can accept this cycle.
- in_instr, input, 32, fetched instruction word.
- in_pc, input, PC_W, PC of in_instr.
- in_exc, input, EXC_W, fetch-stage ExcCode (0 = none; 4 = AdEL).
- out_valid, output, 1, head entry is valid.
- out_ready, input, 1, decode consumes the head this cycle (= !stallD).
- out_instr, output, 32, head instruction; 0 when empty.
- out_pc, output, PC_W, head PC.
- out_exc, output, EXC_W, head ExcCode.
- out_bd, output, 1, head is in a branch delay slot.
- redirect, input, 1, branch/jump at the head resolved taken this cycle; valid only with a head pop.
- flush, input, 1, exception or eret: discard everything.
- count, output, $clog2(DEPTH)+1, current occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, state=NORMAL, last_jmp=0.
  - All entry storage and out_* forced to 0; in_ready=1.
- Push: occurs when in_valid && in_ready; in_ready = (count != DEPTH).
- Pop: occurs when out_valid && out_ready; out_valid = (count != 0).
- Output path: outputs are read combinationally from the head entry. Zero latency from head register to decode; one cycle of latency from push to out_valid.
- Simultaneous push and pop: count unchanged. Push when full is not allowed, even with a pop in the same cycle.
- Pointers: wrap modulo DEPTH.
- Pre-decode jmp flag, set at enqueue for:
  - op = 000100/000101/000110/000111/000001/000010/000011;
  - op = 000000 with func = 001000/001001.
- Entry bd bit = last_jmp at enqueue. last_jmp is updated to the entry's jmp flag on every push.
- Priority within one cycle: flush > redirect > normal push/pop.
- flush:
  - Next edge: count=0, pointers equal, state=NORMAL, last_jmp=0.
  - The same-cycle push is dropped; in_ready is unaffected.
- redirect (head pop required; redirect without a pop is ignored):
  - If at least one entry remains after the pop: keep only the new head (the delay slot); count=1. Any same-cycle push is dropped.
  - If none remains and a push occurs that cycle: that pushed word is the delay slot; count=1.
  - If none remains and no push occurs: enter WAIT_DS. The next push is accepted as the delay slot, then return to NORMAL. No extra filtering is applied; fetch supplies DS then target.
  - last_jmp is cleared on redirect, so the branch-target instruction has bd=0.
- WAIT_DS + flush: return to NORMAL, count=0.
- Exception code: carried unchanged. Decode may overwrite it (RI) downstream; the queue never alters it.
- No combinational path from out_ready to in_ready.

Test Plan:
- Reset and empty:
  - Hold reset=0 mid-stream with 3 entries, then release.
  - Expect count=0, out_valid=0, out_instr=0, in_ready=1. First push appears on out_* one cycle later.
- Fill and wrap (DEPTH=4):
  - Push 6 words PC 0x3000..0x3014 with out_ready=0 for 5 cycles, then 1.
  - Expect in_ready=0 at count=4. Output order 0x3000..0x3014 with no loss or duplication across the pointer wrap.
- Delay-slot tag:
  - Push beq (0x10220003) @0x3000, addu @0x3004, ori @0x3008.
  - Expect out_bd = 0, 1, 0. Also repeat with jr $31 (0x03E00008): same tagging.
- Redirect with DS queued:
  - Queue beq, DS, X, Y; pop beq with redirect=1.
  - Expect count=1, head=DS with out_bd=1. X and Y are gone. The next push has bd=0.
- Redirect with empty queue:
  - Pop a lone j with redirect=1 and in_valid=0.
  - Expect state WAIT_DS. The next push (DS @0x3004) is kept with bd=1. The following push (target) has bd=0.
- Flush precedence:
  - Assert flush, redirect, pop and push in the same cycle with 3 entries queued.
  - Expect count=0, out_valid=0 next cycle. The pushed word is discarded. AdEL (in_exc=4) on a later push is passed through unchanged.
